// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter holding one outstanding burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            s_arvalid,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [7:0]            s_arid,
  input  logic [15:0]           s_arlen,
  input  logic [5:0]            s_arsize,
  input  logic [3:0]            s_arburst,
  output logic [1:0]            s_arready,
  output logic [1:0]            s_rvalid,
  input  logic [1:0]            s_rready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [3:0]            s_rid,
  output logic                  m_arvalid,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [3:0]            m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic [3:0]            m_rid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q;
  logic                grant_q;
  logic                last_q;
  logic                m_arvalid_q;
  logic [ADDR_W-1:0]   m_araddr_q;
  logic [3:0]          m_arid_q;
  logic [7:0]          m_arlen_q;
  logic [2:0]          m_arsize_q;
  logic [1:0]          m_arburst_q;

  logic                win;
  logic                ar_fire;
  logic                r_done;
  logic [ADDR_W-1:0]   sel_addr;
  logic [3:0]          sel_id;
  logic [7:0]          sel_len;
  logic [2:0]          sel_size;
  logic [1:0]          sel_burst;

  always_comb begin
`ifdef AXI_RD_ARB_RR_EN
    if (&s_arvalid) win = ~last_q;
    else            win = s_arvalid[1];
`else
    win = s_arvalid[1] & ~s_arvalid[0];
`endif
  end

`ifndef AXI_RD_ARB_RR_EN
  // last_q is still tracked in fixed-priority builds so both variants share state.
  logic last_unused;
  assign last_unused = last_q;
`endif

  always_comb begin
    if (win) begin
      sel_addr  = s_araddr[2*ADDR_W-1:ADDR_W];
      sel_id    = s_arid[7:4];
      sel_len   = s_arlen[15:8];
      sel_size  = s_arsize[5:3];
      sel_burst = s_arburst[3:2];
    end else begin
      sel_addr  = s_araddr[ADDR_W-1:0];
      sel_id    = s_arid[3:0];
      sel_len   = s_arlen[7:0];
      sel_size  = s_arsize[2:0];
      sel_burst = s_arburst[1:0];
    end
  end

  // The reset term keeps arready low while reset is held, even though IDLE is decoded then.
  assign ar_fire   = (state_q == IDLE) & (|s_arvalid) & reset;
  assign s_arready = ar_fire ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign m_rready = (state_q == DATA) & (grant_q ? s_rready[1] : s_rready[0]);
  assign s_rvalid = (state_q != DATA) ? 2'b00
                  : (grant_q ? {m_rvalid, 1'b0} : {1'b0, m_rvalid});
  assign r_done   = (state_q == DATA) & m_rvalid & m_rready & m_rlast;

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;
  assign s_rid   = m_rid;

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arid    = m_arid_q;
  assign m_arlen   = m_arlen_q;
  assign m_arsize  = m_arsize_q;
  assign m_arburst = m_arburst_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arid_q    <= '0;
      m_arlen_q   <= '0;
      m_arsize_q  <= '0;
      m_arburst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_fire) begin
            m_araddr_q  <= sel_addr;
            m_arid_q    <= sel_id;
            m_arlen_q   <= sel_len;
            m_arsize_q  <= sel_size;
            m_arburst_q <= sel_burst;
            grant_q     <= win;
            last_q      <= win;
            m_arvalid_q <= 1'b1;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (r_done) state_q <= IDLE;
        end
        default: begin
          m_arvalid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised self-checking bench for axi_rd_arbiter against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          s_arvalid;
  logic [2*ADDR_W-1:0] s_araddr;
  logic [7:0]          s_arid;
  logic [15:0]         s_arlen;
  logic [5:0]          s_arsize;
  logic [3:0]          s_arburst;
  logic [1:0]          s_arready;
  logic [1:0]          s_rvalid;
  logic [1:0]          s_rready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic [3:0]          s_rid;
  logic                m_arvalid;
  logic [ADDR_W-1:0]   m_araddr;
  logic [3:0]          m_arid;
  logic [7:0]          m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arready;
  logic                m_rvalid;
  logic                m_rready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic [3:0]          m_rid;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester-side model: pending request per requester and the last winner.
  logic [1:0]        pending;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [3:0]        req_id    [2];
  logic [7:0]        req_len   [2];
  logic [2:0]        req_size  [2];
  logic [1:0]        req_burst [2];
  bit                tb_last;

  function automatic bit pick(input logic [1:0] p, input bit last);
    if (p == 2'b11) begin
`ifdef AXI_RD_ARB_RR_EN
      return !last;
`else
      return 1'b0;
`endif
    end
    return p[1] && !p[0];
  endfunction

  task automatic new_req(input bit r);
    req_addr[r]  = {$urandom, $urandom};
    req_id[r]    = 4'($urandom_range(0, 15));
    req_len[r]   = 8'($urandom_range(0, 3));
    req_size[r]  = 3'($urandom_range(0, 7));
    req_burst[r] = 2'($urandom_range(0, 3));
    pending[r]   = 1'b1;
  endtask

  task automatic drive_ar();
    s_arvalid = pending;
    s_araddr  = {req_addr[1], req_addr[0]};
    s_arid    = {req_id[1], req_id[0]};
    s_arlen   = {req_len[1], req_len[0]};
    s_arsize  = {req_size[1], req_size[0]};
    s_arburst = {req_burst[1], req_burst[0]};
  endtask

  // Runs ADDR then DATA for an accepted request of `owner`; entered just after the accept edge.
  task automatic burst_phase(input bit owner, input int ar_delay, input int stall_at,
                             input int stall_len, input bit rnd);
    int beat, stalls, nbeats, guard;
    logic [1:0] exp_rv;
    nbeats = int'(req_len[owner]) + 1;
    for (int d = 0; d <= ar_delay; d++) begin
      m_arready = (d == ar_delay);
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      @(negedge clock);
      n_checks++; if (m_arvalid !== 1'b1) $display("FAIL addr_arvalid: got %b want 1", m_arvalid); else n_pass++;
      n_checks++;
      if ({m_araddr, m_arid, m_arlen, m_arsize, m_arburst} !==
          {req_addr[owner], req_id[owner], req_len[owner], req_size[owner], req_burst[owner]})
        $display("FAIL addr_fields: got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h",
                 m_araddr, m_arid, m_arlen, m_arsize, m_arburst, req_addr[owner],
                 req_id[owner], req_len[owner], req_size[owner], req_burst[owner]);
      else n_pass++;
      n_checks++; if (s_arready !== 2'b00) $display("FAIL addr_arready: got %b want 00", s_arready); else n_pass++;
      n_checks++; if ({m_rready, s_rvalid} !== 3'b000) $display("FAIL addr_rhold: got %b want 000", {m_rready, s_rvalid}); else n_pass++;
      @(posedge clock); #1;
    end
    m_arready = 1'b0;
    beat = 0; stalls = 0; guard = 0;
    while (beat < nbeats && guard < 200) begin
      guard++;
      m_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_rdata  = {$urandom, $urandom, $urandom, $urandom};
      m_rresp  = 2'($urandom_range(0, 3));
      m_rid    = req_id[owner];
      m_rlast  = (beat == nbeats - 1);
      s_rready = 2'($urandom_range(0, 3));
      if (beat == stall_at && stalls < stall_len && m_rvalid) begin
        s_rready[owner] = 1'b0;
        stalls++;
      end else if (!rnd) begin
        s_rready[owner] = 1'b1;
      end
      exp_rv = m_rvalid ? (2'b01 << owner) : 2'b00;
      @(negedge clock);
      n_checks++; if (s_rvalid !== exp_rv) $display("FAIL data_rvalid: got %b want %b", s_rvalid, exp_rv); else n_pass++;
      n_checks++; if (m_rready !== s_rready[owner]) $display("FAIL data_rready: got %b want %b", m_rready, s_rready[owner]); else n_pass++;
      n_checks++;
      if ({s_rdata, s_rresp, s_rlast, s_rid} !== {m_rdata, m_rresp, m_rlast, m_rid})
        $display("FAIL data_bcast: got %h/%h/%b/%h want %h/%h/%b/%h",
                 s_rdata, s_rresp, s_rlast, s_rid, m_rdata, m_rresp, m_rlast, m_rid);
      else n_pass++;
      @(posedge clock);
      if (m_rvalid && s_rready[owner]) beat++;
      #1;
    end
    if (beat < nbeats) begin
      n_checks++;
      $display("FAIL data_timeout: got %0d beats want %0d", beat, nbeats);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
  endtask

  task automatic test_reset();
    pending = 2'b11; new_req(0); new_req(1); drive_ar();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    s_rready = 2'b11;
    reset = 1'b0;
    #12;
    n_checks++; if (s_arready !== 2'b00) $display("FAIL rst_arready: got %b want 00", s_arready); else n_pass++;
    n_checks++; if ({m_arvalid, m_rready, s_rvalid} !== 4'b0) $display("FAIL rst_valids: got %b want 0000", {m_arvalid, m_rready, s_rvalid}); else n_pass++;
    n_checks++;
    if ({m_araddr, m_arid, m_arlen, m_arsize, m_arburst} !== '0)
      $display("FAIL rst_fields: got %h want 0", {m_araddr, m_arid, m_arlen, m_arsize, m_arburst});
    else n_pass++;
    pending = 2'b00; drive_ar(); m_rvalid = 1'b0; s_rready = 2'b00;
    @(negedge clock); reset = 1'b1; tb_last = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if ({s_arready, m_arvalid} !== 3'b000) $display("FAIL rst_idle: got %b want 000", {s_arready, m_arvalid}); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_single_icache();
    pending = 2'b01;
    req_addr[0] = 64'h8000_0040; req_len[0] = 8'd3; req_id[0] = 4'h5;
    req_size[0] = 3'd4; req_burst[0] = 2'd1;
    drive_ar();
    @(negedge clock);
    n_checks++; if (s_arready !== 2'b01) $display("FAIL single_arready: got %b want 01", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; drive_ar(); tb_last = 1'b0;
    burst_phase(1'b0, 0, -1, 0, 1'b0);
    m_rvalid = 1'b1;
    @(negedge clock);
    n_checks++; if ({m_arvalid, m_rready, s_rvalid, s_arready} !== 6'b0) $display("FAIL single_idle: got %b want 000000", {m_arvalid, m_rready, s_rvalid, s_arready}); else n_pass++;
    @(posedge clock); #1;
    m_rvalid = 1'b0;
  endtask

  task automatic test_contention();
    bit w;
    new_req(0); new_req(1);
    for (int k = 0; k < 3; k++) begin
      drive_ar();
      w = pick(pending, tb_last);
      @(negedge clock);
      n_checks++; if (s_arready !== (2'b01 << w)) $display("FAIL contend_grant%0d: got %b want %b", k, s_arready, 2'b01 << w); else n_pass++;
      @(posedge clock); #1;
      tb_last = w;
      burst_phase(w, $urandom_range(0, 2), -1, 0, 1'b0);
      new_req(w);
    end
    pending = 2'b00; drive_ar();
  endtask

  task automatic test_ar_backpressure();
    pending = 2'b00; new_req(1); req_len[1] = 8'd1; drive_ar();
    @(negedge clock);
    n_checks++; if (s_arready !== 2'b10) $display("FAIL arbp_grant: got %b want 10", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; new_req(0); drive_ar(); tb_last = 1'b1;
    burst_phase(1'b1, 5, -1, 0, 1'b0);
    @(negedge clock);
    n_checks++; if (s_arready !== 2'b01) $display("FAIL arbp_later: got %b want 01", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; drive_ar(); tb_last = 1'b0;
    burst_phase(1'b0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_r_backpressure();
    pending = 2'b00; new_req(0); req_len[0] = 8'd3; drive_ar();
    @(negedge clock);
    n_checks++; if (s_arready !== 2'b01) $display("FAIL rbp_grant: got %b want 01", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; drive_ar(); tb_last = 1'b0;
    burst_phase(1'b0, 1, 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid_data();
    pending = 2'b00; new_req(0); req_len[0] = 8'd3; drive_ar();
    @(negedge clock);
    n_checks++; if (s_arready !== 2'b01) $display("FAIL mid_grant: got %b want 01", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; drive_ar(); m_arready = 1'b1;
    @(posedge clock); #1;
    m_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b01; m_rdata = {4{$urandom}};
      @(negedge clock);
      n_checks++; if ({s_rvalid, m_rready} !== 3'b011) $display("FAIL mid_beat%0d: got %b want 011", b, {s_rvalid, m_rready}); else n_pass++;
      @(posedge clock); #1;
    end
    m_rvalid = 1'b1; pending = 2'b11; new_req(1); drive_ar();
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({m_arvalid, m_rready, s_rvalid, s_arready} !== 6'b0) $display("FAIL mid_async: got %b want 000000", {m_arvalid, m_rready, s_rvalid, s_arready}); else n_pass++;
    n_checks++;
    if ({m_araddr, m_arid, m_arlen, m_arsize, m_arburst} !== '0)
      $display("FAIL mid_fields: got %h want 0", {m_araddr, m_arid, m_arlen, m_arsize, m_arburst});
    else n_pass++;
    @(negedge clock);
    reset = 1'b1; tb_last = 1'b0; m_rvalid = 1'b0; s_rready = 2'b00;
    pending = 2'b00; new_req(0); drive_ar();
    #1;
    n_checks++; if (s_arready !== 2'b01) $display("FAIL mid_idle: got %b want 01", s_arready); else n_pass++;
    @(posedge clock); #1;
    pending = 2'b00; drive_ar();
    burst_phase(1'b0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    bit w;
    pending = 2'b00;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pending[r] && $urandom_range(0, 1) == 1) new_req(r[0]);
      if (pending == 2'b00) new_req(1'($urandom_range(0, 1)));
      drive_ar();
      w = pick(pending, tb_last);
      @(negedge clock);
      n_checks++; if (s_arready !== (2'b01 << w)) $display("FAIL rand_grant%0d: got %b want %b", it, s_arready, 2'b01 << w); else n_pass++;
      @(posedge clock); #1;
      pending[w] = 1'b0; tb_last = w; drive_ar();
      burst_phase(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end
    pending = 2'b00; drive_ar();
    @(posedge clock); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_icache();
    test_contention();
    test_ar_backpressure();
    test_r_backpressure();
    test_reset_mid_data();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
